// File: rtl/timer_axil_ctrl.sv
// AXI4-Lite register block for the 32-bit timer core: CTRL/LOAD/COUNT/STATUS.
// Latency: write handshake -> pulse and bvalid next cycle; read handshake -> rvalid next cycle.
// Backpressure: one outstanding write and one outstanding read; a channel stalls until its response is taken.
module timer_axil_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter logic [31:0] LOAD_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  // write address / data / response
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  // read address / data
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  // timer core side
  output logic              tmr_start,
  output logic              tmr_stop,
  output logic              tmr_irq_clear,
  output logic [31:0]       tmr_load_val,
  input  logic [31:0]       tmr_cur_count,
  input  logic              tmr_irq,
  output logic              irq_o
);

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_LOAD   = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e    w_state_q;
  r_state_e    r_state_q;

  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        start_q;
  logic        stop_q;
  logic        irq_clear_q;
  logic        run_q;
  logic        irq_en_q;
  logic [31:0] load_q;
  logic [31:0] load_d;

  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] rd_dat_d;

  logic [1:0]  wr_sel;
  logic [1:0]  rd_sel;
  logic        wr_fire;
  logic        rd_fire;
  logic        ctrl_wr_en;
  logic        stat_wr_en;

  // Only bits [3:2] select a register; the rest of each address is don't-care.
  logic        unused_addr;
  assign unused_addr = ^{s_awaddr, s_araddr};

  assign wr_sel = s_awaddr[3:2];
  assign rd_sel = s_araddr[3:2];

  // AW and W are taken together on one edge, never one without the other.
  assign wr_fire    = (w_state_q == W_IDLE) && s_awvalid && s_wvalid;
  assign rd_fire    = (r_state_q == R_IDLE) && arready_q && s_arvalid;
  assign ctrl_wr_en = wr_fire && (wr_sel == SEL_CTRL) && s_wstrb[0];
  assign stat_wr_en = wr_fire && (wr_sel == SEL_STATUS) && s_wstrb[0];

  assign s_awready = wr_fire;
  assign s_wready  = wr_fire;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;

  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  assign tmr_start     = start_q;
  assign tmr_stop      = stop_q;
  assign tmr_irq_clear = irq_clear_q;
  assign tmr_load_val  = load_q;
  assign irq_o         = tmr_irq & irq_en_q;

  // LOAD next value: byte-lane merge of the write data under wstrb.
  always_comb begin
    load_d = load_q;
    if (wr_fire && (wr_sel == SEL_LOAD)) begin
      for (int b = 0; b < 4; b++) begin
        if (s_wstrb[b]) begin
          load_d[8*b +: 8] = s_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data source, sampled from current register state so a same-edge write is not visible.
  always_comb begin
    rd_dat_d = 32'h0;
    case (rd_sel)
      SEL_CTRL:   rd_dat_d = {29'h0, irq_en_q, run_q, 1'b0};
      SEL_LOAD:   rd_dat_d = load_q;
      SEL_COUNT:  rd_dat_d = tmr_cur_count;
      SEL_STATUS: rd_dat_d = {31'h0, tmr_irq};
      default:    rd_dat_d = 32'h0;
    endcase
  end

  // Write FSM: register update, one-cycle core pulses, and the write response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q   <= W_IDLE;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      irq_clear_q <= 1'b0;
      run_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      load_q      <= LOAD_RST;
    end else begin
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      irq_clear_q <= 1'b0;
      load_q      <= load_d;
      case (w_state_q)
        W_IDLE: begin
          if (wr_fire) begin
            bvalid_q  <= 1'b1;
            bresp_q   <= (wr_sel == SEL_COUNT) ? RESP_SLVERR : RESP_OKAY;
            w_state_q <= W_RESP;
          end
          if (ctrl_wr_en) begin
            irq_en_q <= s_wdata[2];
            // STOP wins when both command bits are set in one write.
            if (s_wdata[1]) begin
              stop_q <= 1'b1;
              run_q  <= 1'b0;
            end else if (s_wdata[0]) begin
              start_q <= 1'b1;
              run_q   <= 1'b1;
            end
          end
          if (stat_wr_en && s_wdata[0]) begin
            irq_clear_q <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: capture data on the AR handshake and hold it until the master takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (rd_fire) begin
            rdata_q   <= rd_dat_d;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule
